// File: rtl/vid_mem_arb.sv
// vid_mem_arb: shares one memory port between line-buffer scan fetches and single-word host writes.
module vid_mem_arb #(
  parameter logic [11:0] ACTIVE_H   = 12'd1920,
  parameter logic [10:0] ACTIVE_V   = 11'd1080,
  parameter logic [10:0] TOTAL_V    = 11'd1125,
  parameter logic [8:0]  LINE_WORDS = 9'd480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] hcnt,
  input  logic [10:0] vcnt,
  input  logic        host_req,
  input  logic [19:0] host_addr,
  input  logic [31:0] host_wdata,
  output logic        host_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic [19:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        lb_we,
  output logic [8:0]  lb_addr,
  output logic [31:0] lb_wdata,
  output logic        busy,
  output logic        underrun
);
  typedef enum logic [1:0] {IDLE, SCAN, HOST} state_t;
  state_t      r_state, w_next;
  logic        r_pend;
  logic [8:0]  r_wcnt;
  logic [19:0] r_saddr;
  logic [10:0] w_next_line;
  logic        w_trig, w_scan_ack, w_host_done, w_last;
  logic [19:0] w_saddr_inc;
  assign w_next_line = (vcnt == TOTAL_V - 11'd1) ? 11'd0 : vcnt + 11'd1;
  assign w_trig      = (hcnt == ACTIVE_H) && (w_next_line < ACTIVE_V);
  assign w_scan_ack  = (r_state == SCAN) && mem_ack;
  assign w_host_done = (r_state == HOST) && mem_ack;
  assign w_last      = r_wcnt == LINE_WORDS - 9'd1;
  assign w_saddr_inc = r_saddr + {19'd0, w_scan_ack};
  assign busy        = r_pend;
  // Every scan word passes through IDLE, which forces the gap in mem_req;
  // the registered host_ack blocks re-entering HOST on the request just served.
  always_comb begin
    w_next    = r_state;
    mem_req   = r_state != IDLE;
    mem_we    = r_state == HOST;
    mem_addr  = (r_state == SCAN) ? r_saddr : (r_state == HOST) ? host_addr : 20'd0;
    mem_wdata = (r_state == HOST) ? host_wdata : 32'd0;
    if (r_state == IDLE)
      w_next = r_pend ? SCAN : (host_req && !host_ack) ? HOST : IDLE;
    else if (r_state == SCAN)
      w_next = (mem_ack || w_trig) ? IDLE : SCAN;
    else
      w_next = mem_ack ? IDLE : HOST;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_pend   <= 1'b0;
      r_wcnt   <= 9'd0;
      r_saddr  <= 20'd0;
      host_ack <= 1'b0;
      lb_we    <= 1'b0;
      lb_addr  <= 9'd0;
      lb_wdata <= 32'd0;
      underrun <= 1'b0;
    end else begin
      r_state  <= w_next;
      host_ack <= w_host_done;
      lb_we    <= w_scan_ack;
      r_saddr  <= w_saddr_inc;
      if (w_scan_ack) begin
        lb_addr  <= r_wcnt;
        lb_wdata <= mem_rdata;
        r_wcnt   <= w_last ? 9'd0 : r_wcnt + 9'd1;
        if (w_last) r_pend <= 1'b0;
      end
      if (w_trig) begin
        r_pend <= 1'b1;
        r_wcnt <= 9'd0;
        r_saddr <= (w_next_line == 11'd0) ? 20'd0 : w_saddr_inc;
        if (r_pend && !(w_scan_ack && w_last)) underrun <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_vid_mem_arb.sv
// tb_vid_mem_arb: directed scenarios with a memory responder and scoreboard queues for memory and line-buffer traffic.
module tb_vid_mem_arb;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [11:0] hcnt = 12'd0;
  logic [10:0] vcnt = 11'd0;
  logic        host_req = 1'b0;
  logic [19:0] host_addr = 20'd0;
  logic [31:0] host_wdata = 32'd0;
  logic        host_ack, mem_req, mem_we, lb_we, busy, underrun;
  logic [19:0] mem_addr;
  logic [31:0] mem_wdata, lb_wdata;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_ack = 1'b0;
  logic [8:0]  lb_addr;
  typedef struct {logic we; logic [19:0] addr; logic [31:0] wd;} mem_t;
  typedef struct {logic [8:0] addr; logic [31:0] d;} lb_t;
  mem_t exp_mem[$];
  lb_t  exp_lb[$];
  int total = 0, bad = 0;
  int ack_dly = 0;
  bit ack_en = 1'b1;

  vid_mem_arb dut (
    .clk(clk), .reset(reset), .hcnt(hcnt), .vcnt(vcnt),
    .host_req(host_req), .host_addr(host_addr), .host_wdata(host_wdata), .host_ack(host_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .lb_we(lb_we), .lb_addr(lb_addr), .lb_wdata(lb_wdata), .busy(busy), .underrun(underrun)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input logic [19:0] a);
    return {a[11:0], a};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_line(input int a);
    for (int i = 0; i < 480; i++) begin
      exp_mem.push_back('{1'b0, 20'(a + i), 32'd0});
      exp_lb.push_back('{9'(i), pat(20'(a + i))});
    end
  endtask

  task automatic pulse_trig(input logic [10:0] v);
    @(negedge clk);
    vcnt = v;
    hcnt = 12'd1920;
    @(negedge clk);
    hcnt = 12'd0;
  endtask

  task automatic wait_done(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 5000 && !ok; i++) begin
      @(negedge clk);
      ok = !busy && exp_mem.size() == 0 && exp_lb.size() == 0;
    end
    chk(tag, 64'(ok), 64'd1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_flags"}, {58'd0, mem_req, mem_we, host_ack, lb_we, busy, underrun}, 64'd0);
    chk({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
    chk({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
    chk({tag, "_lb_addr"}, 64'(lb_addr), 64'd0);
    chk({tag, "_lb_wdata"}, 64'(lb_wdata), 64'd0);
  endtask

  // memory responder: acks after ack_dly waiting cycles, checks each accepted transaction
  initial begin
    int w = 0;
    mem_t e;
    forever begin
      @(negedge clk);
      if (mem_ack) begin
        mem_ack = 1'b0;
        w = 0;
      end else if (mem_req && ack_en && reset) begin
        if (w >= ack_dly) begin
          mem_ack = 1'b1;
          mem_rdata = pat(mem_addr);
          w = 0;
          if (exp_mem.size() == 0) chk("mem_unexpected", 64'(mem_addr), 64'hFFFFF);
          else begin
            e = exp_mem.pop_front();
            chk("mem_we", 64'(mem_we), 64'(e.we));
            chk("mem_addr", 64'(mem_addr), 64'(e.addr));
            if (e.we) chk("mem_wdata", 64'(mem_wdata), 64'(e.wd));
          end
        end else w++;
      end else w = 0;
    end
  end

  initial begin
    lb_t e;
    forever begin
      @(negedge clk);
      if (lb_we) begin
        if (exp_lb.size() == 0) chk("lb_unexpected", 64'(lb_addr), 64'h1FF);
        else begin
          e = exp_lb.pop_front();
          chk("lb_addr", 64'(lb_addr), 64'(e.addr));
          chk("lb_wdata", 64'(lb_wdata), 64'(e.d));
        end
      end
    end
  end

  initial begin
    bit ok;
    int n;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset = 1'b1;
    // first line of frame fetched from address 0
    push_line(0);
    pulse_trig(11'd1124);
    chk("busy_after_trig", 64'(busy), 64'd1);
    wait_done("line0_done");
    chk("line0_busy", 64'(busy), 64'd0);
    chk("line0_underrun", 64'(underrun), 64'd0);
    // second line continues at the running address
    push_line(480);
    pulse_trig(11'd0);
    wait_done("line1_done");
    pulse_trig(11'd1079);
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (mem_req) n++;
    end
    chk("no_trig_mem_req", 64'(n), 64'd0);
    chk("no_trig_busy", 64'(busy), 64'd0);
    // host request waits behind a whole scan line
    push_line(960);
    exp_mem.push_back('{1'b1, 20'h12345, 32'hDEADBEEF});
    pulse_trig(11'd1);
    host_req = 1'b1;
    host_addr = 20'h12345;
    host_wdata = 32'hDEADBEEF;
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      ok = host_ack;
    end
    chk("host1_ack_seen", 64'(ok), 64'd1);
    chk("host1_after_scan", 64'(exp_mem.size() + exp_lb.size()), 64'd0);
    host_req = 1'b0;
    @(negedge clk);
    chk("host1_ack_pulse", {62'd0, host_ack, mem_req}, 64'd0);
    // slow host write with a trigger arriving mid-transaction
    ack_dly = 5;
    exp_mem.push_back('{1'b1, 20'hABCDE, 32'h12345678});
    push_line(1440);
    host_req = 1'b1;
    host_addr = 20'hABCDE;
    host_wdata = 32'h12345678;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = mem_req;
    end
    chk("host2_req_seen", 64'(ok), 64'd1);
    pulse_trig(11'd2);
    chk("host2_not_preempted", {62'd0, mem_req, mem_we}, 64'd3);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = host_ack;
    end
    chk("host2_ack_seen", 64'(ok), 64'd1);
    chk("host2_idle_gap", {62'd0, mem_req, busy}, 64'd1);
    host_req = 1'b0;
    @(negedge clk);
    chk("host2_scan_next", {62'd0, mem_req, mem_we}, 64'd2);
    chk("host2_scan_addr", 64'(mem_addr), 64'd1440);
    ack_dly = 0;
    wait_done("line3_done");
    // deadline miss: no acks, then a second trigger
    ack_en = 1'b0;
    pulse_trig(11'd3);
    repeat (3) @(negedge clk);
    chk("stall_req", 64'(mem_req), 64'd1);
    chk("stall_addr", 64'(mem_addr), 64'd1920);
    chk("stall_underrun", 64'(underrun), 64'd0);
    pulse_trig(11'd4);
    chk("underrun_set", {62'd0, underrun, busy}, 64'd3);
    push_line(1920);
    ack_en = 1'b1;
    wait_done("restart_done");
    chk("underrun_sticky", 64'(underrun), 64'd1);
    // reset in the middle of a scan
    ack_en = 1'b0;
    pulse_trig(11'd5);
    repeat (3) @(negedge clk);
    chk("midscan_req", 64'(mem_req), 64'd1);
    reset = 1'b0;
    @(negedge clk);
    chk_zero("midscan_reset");
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_reset_quiet", {62'd0, mem_req, busy}, 64'd0);
    chk("queues_empty", 64'(exp_mem.size() + exp_lb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
